// File: rtl/mini16_uart_pkg.sv
// Shared definitions for the mini16 UART: FSM state encodings and bit-period helpers.
package mini16_uart_pkg;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam int MIN_DIV = 4;

   function automatic int calc_div(input int clk_hz, input int sclk_hz);
      return clk_hz / sclk_hz;
   endfunction

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mini16_uart_rx.sv
// UART receiver: 2-flop synchronizer, centre-sampling frame FSM, data_rx/re outputs.
module mini16_uart_rx
   import mini16_uart_pkg::*;
#(
   parameter int DIV   = 10,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rxd,
   output logic             re,
   output logic [WIDTH-1:0] data_rx
);

   localparam int CW = width_of(DIV);
   localparam int BW = width_of(WIDTH);
   localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_END = CW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   rx_state_t        state, state_nxt;
   logic             sync1, sync2, sync_q;
   logic [CW-1:0]    cnt;
   logic [BW-1:0]    idx;
   logic [WIDTH-1:0] shreg;
   logic             cnt_clr, do_shift, do_load;

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      do_shift  = 1'b0;
      do_load   = 1'b0;
      case (state)
         RX_IDLE: begin
            // A falling edge re-arms reception; after a framing error the line
            // must first return high before another edge can be seen.
            if (sync_q && !sync2) begin
               state_nxt = RX_START;
               cnt_clr   = 1'b1;
            end
         end
         RX_START: begin
            if (cnt == HALF_END) begin
               cnt_clr   = 1'b1;
               state_nxt = sync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == FULL_END) begin
               cnt_clr  = 1'b1;
               do_shift = 1'b1;
               if (idx == LAST_BIT) state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == FULL_END) begin
               cnt_clr   = 1'b1;
               do_load   = sync2;
               state_nxt = RX_IDLE;
            end
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RX_IDLE;
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         sync_q  <= 1'b1;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         re      <= 1'b0;
         data_rx <= '0;
      end else begin
         state  <= state_nxt;
         sync1  <= rxd;
         sync2  <= sync1;
         sync_q <= sync2;
         cnt    <= (cnt_clr || state == RX_IDLE) ? '0 : cnt + 1'b1;
         if (state != RX_DATA) idx <= '0;
         else if (do_shift)    idx <= idx + 1'b1;
         if (do_shift) shreg <= {sync2, shreg[WIDTH-1:1]};
         re <= do_load;
         if (do_load) data_rx <= shreg;
      end
   end

endmodule

// File: rtl/mini16_uart.sv
// Full-duplex UART: inline transmitter plus mini16_uart_rx receiver.
module mini16_uart
   import mini16_uart_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int SCLK_HZ = 115200,
   parameter int WIDTH   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rxd,
   input  logic             start,
   input  logic [WIDTH-1:0] data_tx,
   output logic             txd,
   output logic             busy,
   output logic             re,
   output logic [WIDTH-1:0] data_rx
);

   localparam int DIV = calc_div(CLK_HZ, SCLK_HZ);
   localparam int CW  = width_of(DIV);
   localparam int BW  = width_of(WIDTH);
   localparam logic [CW-1:0] FULL_END = CW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   if (DIV < MIN_DIV) begin : g_div_check
      $error("mini16_uart: CLK_HZ/SCLK_HZ must be at least 4");
   end

   tx_state_t        state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [BW-1:0]    idx;
   logic [WIDTH-1:0] shreg, shreg_sh;
   logic             bit_end, txd_nxt, load, shift;

   assign bit_end  = (cnt == FULL_END);
   assign shreg_sh = shreg >> 1;
   assign busy     = (state != TX_IDLE);

   // txd is registered; the next line level is chosen alongside the transition.
   always_comb begin
      state_nxt = state;
      txd_nxt   = txd;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         TX_IDLE: begin
            if (start) begin
               state_nxt = TX_START;
               txd_nxt   = 1'b0;
               load      = 1'b1;
            end
         end
         TX_START: begin
            if (bit_end) begin
               state_nxt = TX_DATA;
               txd_nxt   = shreg[0];
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               shift = 1'b1;
               if (idx == LAST_BIT) begin
                  state_nxt = TX_STOP;
                  txd_nxt   = 1'b1;
               end else begin
                  txd_nxt = shreg_sh[0];
               end
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               state_nxt = TX_IDLE;
               txd_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = TX_IDLE;
            txd_nxt   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= TX_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         txd   <= 1'b1;
      end else begin
         state <= state_nxt;
         txd   <= txd_nxt;
         cnt   <= (state == TX_IDLE || bit_end) ? '0 : cnt + 1'b1;
         if (state != TX_DATA) idx <= '0;
         else if (bit_end)     idx <= idx + 1'b1;
         if (load)       shreg <= data_tx;
         else if (shift) shreg <= shreg_sh;
      end
   end

   mini16_uart_rx #(
      .DIV   (DIV),
      .WIDTH (WIDTH)
   ) u_rx (
      .clk     (clk),
      .reset   (reset),
      .rxd     (rxd),
      .re      (re),
      .data_rx (data_rx)
   );

endmodule

// File: tb/tb_mini16_uart.sv
// Scoreboard bench for mini16_uart: loopback and directly driven RX frames.
`timescale 1ns/1ps
module tb_mini16_uart;

   localparam int CLK_HZ  = 50000000;
   localparam int SCLK_HZ = 5000000;
   localparam int DIV     = CLK_HZ / SCLK_HZ;
   localparam int WIDTH   = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] data_tx;
   logic             txd, busy, re;
   logic [WIDTH-1:0] data_rx;
   logic             loop, rxd_drv, rxd;

   logic [WIDTH-1:0] tx_exp[$];
   logic [WIDTH-1:0] rx_exp[$];
   logic [WIDTH-1:0] last_w;
   int               checks = 0;
   int               errors = 0;

   assign rxd = loop ? txd : rxd_drv;

   always #5 clk = ~clk;

   mini16_uart #(
      .CLK_HZ  (CLK_HZ),
      .SCLK_HZ (SCLK_HZ),
      .WIDTH   (WIDTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rxd     (rxd),
      .start   (start),
      .data_tx (data_tx),
      .txd     (txd),
      .busy    (busy),
      .re      (re),
      .data_rx (data_rx)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] w, input bit expect_rx);
      int n;
      n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("send_wait_busy_low", n < 3000, 1);
      start   = 1'b1;
      data_tx = w;
      tx_exp.push_back(w);
      if (expect_rx) begin
         rx_exp.push_back(w);
         last_w = w;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drive_frame(input logic [WIDTH-1:0] w, input logic stop_bit);
      logic [WIDTH+1:0] fr;
      fr = {stop_bit, w, 1'b0};
      loop = 1'b0;
      if (stop_bit) begin
         rx_exp.push_back(w);
         last_w = w;
      end
      for (int k = 0; k < WIDTH + 2; k++) begin
         rxd_drv = fr[k];
         repeat (DIV) @(negedge clk);
      end
      rxd_drv = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!(rx_exp.size() == 0 && tx_exp.size() == 0 && busy === 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending_rx", rx_exp.size(), 0);
      repeat (30) @(negedge clk);
      check("data_rx_hold", data_rx, last_w);
   endtask

   // TX monitor: on each frame start, compare the whole txd waveform with the expected word.
   initial begin : tx_mon
      logic [WIDTH-1:0] w;
      logic [WIDTH+1:0] fr;
      int bad;
      bit aborted;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && busy === 1'b1) begin
            check("tx_frame_expected", tx_exp.size() != 0, 1);
            w  = (tx_exp.size() != 0) ? tx_exp.pop_front() : '0;
            fr = {1'b1, w, 1'b0};
            bad = 0;
            aborted = 0;
            for (int j = 0; j < (WIDTH + 2) * DIV; j++) begin
               if (j > 0) @(negedge clk);
               if (reset === 1'b1) begin
                  aborted = 1;
                  break;
               end
               if (txd !== fr[j / DIV] || busy !== 1'b1) bad++;
            end
            if (!aborted) begin
               check("tx_frame_bad_samples", bad, 0);
               @(negedge clk);
               if (reset === 1'b0) begin
                  check("tx_busy_falls", busy, 0);
                  check("tx_line_idle", txd, 1);
               end
            end
         end
      end
   end

   // RX monitor: every re pulse pops the oldest expected word.
   initial begin : rx_mon
      logic re_prev;
      logic [WIDTH-1:0] w;
      re_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (re === 1'b1) begin
            check("re_single_cycle", re_prev, 0);
            check("re_expected", rx_exp.size() != 0, 1);
            if (rx_exp.size() != 0) begin
               w = rx_exp.pop_front();
               check("rx_data", data_rx, w);
            end
         end
         re_prev = (re === 1'b1);
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [WIDTH-1:0] w;
      reset   = 1'b1;
      start   = 1'b0;
      data_tx = '0;
      loop    = 1'b1;
      rxd_drv = 1'b1;
      last_w  = '0;

      repeat (3) @(negedge clk);
      start   = 1'b1;
      data_tx = 8'hFF;
      @(negedge clk);
      check("reset_txd", txd, 1);
      check("reset_busy", busy, 0);
      check("reset_re", re, 0);
      check("reset_data_rx", data_rx, 0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("start_in_reset_ignored", busy, 0);

      // Loopback 'A'
      send(8'h41, 1);
      drain();

      // Back-to-back frames
      send(8'h55, 1);
      send(8'hAA, 1);
      drain();

      // Glitch on rxd
      loop    = 1'b0;
      rxd_drv = 1'b0;
      repeat (3) @(negedge clk);
      rxd_drv = 1'b1;
      drain();

      // Framing error followed by a good frame
      drive_frame(8'h3C, 1'b0);
      repeat (5) @(negedge clk);
      check("framing_data_rx_kept", data_rx, last_w);
      drive_frame(8'h12, 1'b1);
      drain();

      // Start while busy is ignored
      loop = 1'b1;
      send(8'h77, 1);
      repeat (49) @(negedge clk);
      start   = 1'b1;
      data_tx = 8'h11;
      @(negedge clk);
      start = 1'b0;
      check("busy_during_ignored_start", busy, 1);
      drain();

      // Reset in the middle of a transmitted frame
      send(8'h41, 0);
      repeat (39) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_txd", txd, 1);
      check("midreset_busy", busy, 0);
      check("midreset_re", re, 0);
      @(negedge clk);
      reset  = 1'b0;
      last_w = '0;
      check("midreset_data_rx", data_rx, 0);
      send(8'h41, 1);
      drain();

      // Random loopback traffic, mixing back-to-back and spaced frames
      for (int i = 0; i < 12; i++) begin
         w = WIDTH'($urandom_range(0, 255));
         send(w, 1);
         if ($urandom_range(0, 1) == 1) begin
            while (busy !== 1'b0) @(negedge clk);
            repeat ($urandom_range(1, 20)) @(negedge clk);
         end
      end
      drain();

      // Random directly driven frames, some with a bad stop bit
      for (int i = 0; i < 12; i++) begin
         w = WIDTH'($urandom_range(0, 255));
         drive_frame(w, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         repeat ($urandom_range(2, 15)) @(negedge clk);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
